// File: rtl/chase_pkg.sv
// Shared constants for the lamp-chase initiator/checker.
package chase_pkg;

  // FSM state encodings
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StGap   = 3'd3;
  localparam logic [2:0] StError = 3'd4;

  // Error cause codes
  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrStep    = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;
  localparam logic [1:0] ErrDone    = 2'd3;

  localparam logic [7:0] LAMP_FIRST = 8'b1000_0000;
  localparam logic [7:0] LAMP_LAST  = 8'b0000_0001;

  // A new lamp value is legal if it repeats the expected lamp, moves one place right,
  // or goes dark after the last lamp.
  function automatic logic lamp_step_legal(input logic [7:0] lamp, input logic [7:0] exp_lamp);
    return (lamp == exp_lamp) ||
           ((lamp == (exp_lamp >> 1)) && (exp_lamp != LAMP_LAST)) ||
           ((lamp == 8'd0) && (exp_lamp == LAMP_LAST));
  endfunction

endpackage

// File: rtl/chase_tick_gen.sv
// Tick generator: one-cycle tick every TICK_DIV clocks, restartable via clr.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(TICK_DIV - 1));

  // Next count: restart on clr, wrap on tick
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chase_master.sv
// Lamp-chase initiator/checker: runs batches of rounds against the responder,
// checks each lamp step and reports progress and sticky errors.
module chase_master
  import chase_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned ROUNDS        = 4,
  parameter int unsigned TIMEOUT_TICKS = 3,
  parameter int unsigned GAP_TICKS     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       done_in,
  input  logic [7:0] lump_in,
  output logic       start_out,
  output logic       busy,
  output logic [7:0] rounds_done,
  output logic       batch_done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned ToW  = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned GapW = $clog2(GAP_TICKS + 1);

  logic [2:0]      state_q, state_d;
  logic [7:0]      exp_q, exp_d;
  logic [ToW-1:0]  to_q, to_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [7:0]      rounds_q, rounds_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            batch_q, batch_d;
  logic [7:0]      prev_lump_q;
  logic            prev_done_q;

  logic       tick, tick_clr;
  logic       lamp_ev, done_ev, lamp_bad;
  logic [7:0] exp_eff;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign lamp_ev = (lump_in != prev_lump_q);
  assign done_ev = done_in & ~prev_done_q;

  assign start_out   = (state_q == StStart);
  assign busy        = (state_q != StIdle);
  assign rounds_done = rounds_q;
  assign batch_done  = batch_q;
  assign err         = err_q;
  assign err_code    = code_q;

  // Next-state logic for the batch FSM and its bookkeeping
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    to_d     = to_q;
    gap_d    = gap_q;
    rounds_d = rounds_q;
    err_d    = err_q;
    code_d   = code_q;
    batch_d  = 1'b0;
    tick_clr = 1'b0;
    lamp_bad = 1'b0;
    exp_eff  = exp_q;

    case (state_q)
      StIdle: begin
        if (go) begin
          rounds_d = '0;
          err_d    = 1'b0;
          code_d   = ErrNone;
          state_d  = StStart;
          tick_clr = 1'b1;
        end
      end

      StStart: begin
        exp_d = LAMP_FIRST;
        to_d  = '0;
        if (tick) begin
          state_d = StWait;
        end
      end

      StWait: begin
        // Lamp event is judged first so a simultaneous done sees the updated exp
        if (lamp_ev) begin
          if (lamp_step_legal(lump_in, exp_q)) begin
            to_d = '0;
            if (lump_in != 8'd0) begin
              exp_eff = lump_in;
            end
          end else begin
            lamp_bad = 1'b1;
          end
        end
        exp_d = exp_eff;

        if (lamp_bad) begin
          state_d = StError;
          err_d   = 1'b1;
          code_d  = ErrStep;
        end else if (done_ev) begin
          if ((exp_eff == LAMP_LAST) && (lump_in == 8'd0)) begin
            rounds_d = rounds_q + 8'd1;
            if ((rounds_q + 8'd1) == 8'(ROUNDS)) begin
              batch_d = 1'b1;
              state_d = StIdle;
            end else begin
              gap_d    = '0;
              tick_clr = 1'b1;
              state_d  = StGap;
            end
          end else begin
            state_d = StError;
            err_d   = 1'b1;
            code_d  = ErrDone;
          end
        end else if (!lamp_ev && tick) begin
          if ((to_q + ToW'(1)) == ToW'(TIMEOUT_TICKS)) begin
            state_d = StError;
            err_d   = 1'b1;
            code_d  = ErrTimeout;
          end else begin
            to_d = to_q + ToW'(1);
          end
        end
      end

      StGap: begin
        if (tick) begin
          if ((gap_q + GapW'(1)) == GapW'(GAP_TICKS)) begin
            tick_clr = 1'b1;
            state_d  = StStart;
          end else begin
            gap_d = gap_q + GapW'(1);
          end
        end
      end

      StError: begin
        if (go) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and edge-detect registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      exp_q       <= LAMP_FIRST;
      to_q        <= '0;
      gap_q       <= '0;
      rounds_q    <= '0;
      err_q       <= 1'b0;
      code_q      <= ErrNone;
      batch_q     <= 1'b0;
      prev_lump_q <= '0;
      prev_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      to_q        <= to_d;
      gap_q       <= gap_d;
      rounds_q    <= rounds_d;
      err_q       <= err_d;
      code_q      <= code_d;
      batch_q     <= batch_d;
      prev_lump_q <= lump_in;
      prev_done_q <= done_in;
    end
  end

endmodule

// File: tb/tb_chase_master.sv
// Self-checking bench for chase_master with a behavioural lamp responder.
module tb_chase_master;

  localparam int unsigned TD = 4;
  localparam int unsigned NR = 2;
  localparam int unsigned TO = 3;
  localparam int unsigned GT = 2;

  logic       clk = 1'b0;
  logic       reset, go, done_in;
  logic [7:0] lump_in;
  logic       start_out, busy, batch_done, err;
  logic [7:0] rounds_done;
  logic [1:0] err_code;

  chase_master #(
    .TICK_DIV     (TD),
    .ROUNDS       (NR),
    .TIMEOUT_TICKS(TO),
    .GAP_TICKS    (GT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .done_in    (done_in),
    .lump_in    (lump_in),
    .start_out  (start_out),
    .busy       (busy),
    .rounds_done(rounds_done),
    .batch_done (batch_done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard of expected rounds_done values, one per legal completion driven
  logic [7:0] exp_q[$];
  int         rounds_model = 0;
  int         starts       = 0;
  int         bd_pulses    = 0;
  logic       prev_start   = 1'b0;
  logic [7:0] prev_rd      = 8'd0;

  logic [7:0] walk [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

  // fault: 0 clean (+stray go mid-WAIT), 1 skip 20->08, 2 stall at 10, 3 done at 04,
  //        4 01->00 together with done
  typedef struct {
    int fault;
    int fround;
    int e_err;
    int e_code;
    int e_rounds;
    int e_batch;
    int e_starts;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: counts start pulses / batch pulses and pops the scoreboard
  always @(negedge clk) begin
    if (start_out === 1'b1 && prev_start !== 1'b1) starts++;
    prev_start = start_out;
    if (batch_done === 1'b1) bd_pulses++;
    if (rounds_done !== prev_rd && rounds_done !== 8'd0) begin
      if (exp_q.size() == 0) begin
        check("rounds_unexpected", 32'(rounds_done), 32'hFFFF_FFFF);
      end else begin
        check("rounds_done", 32'(rounds_done), 32'(exp_q.pop_front()));
      end
    end
    prev_rd = rounds_done;
  end

  // Responder for one round: wait for start, then walk lamps one step per tick
  task automatic run_round(input int f);
    int n;
    n = 0;
    while (start_out !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 32'(start_out === 1'b1), 32'd1);
    if (start_out !== 1'b1) return;
    n = 0;
    while (start_out === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("start_len", 32'(n), 32'(TD));

    for (int i = 0; i < 9; i++) begin
      if (f == 1 && i == 3) begin
        lump_in = 8'h08;
        @(negedge clk);
        check("skip_err", 32'(err), 32'd1);
        check("skip_code", 32'(err_code), 32'd1);
        check("skip_start", 32'(start_out), 32'd0);
        return;
      end
      if (f == 3 && i == 6) begin
        done_in = 1'b1;
        @(negedge clk);
        check("early_code", 32'(err_code), 32'd3);
        done_in = 1'b0;
        return;
      end
      lump_in = walk[i];
      if (f == 4 && i == 8) begin
        rounds_model++;
        exp_q.push_back(8'(rounds_model));
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        return;
      end
      if (f == 2 && i == 3) begin
        for (int k = 1; k <= 12; k++) begin
          @(negedge clk);
          if (k == 11) check("stall_early", 32'(err), 32'd0);
          if (k == 12) begin
            check("stall_err", 32'(err), 32'd1);
            check("stall_code", 32'(err_code), 32'd2);
          end
        end
        return;
      end
      if (f == 0 && i == 2) begin
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (TD - 1) @(negedge clk);
      end else begin
        repeat (TD) @(negedge clk);
      end
    end
    // Lamps are dark; raise done one tick later
    rounds_model++;
    exp_q.push_back(8'(rounds_model));
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 0, 0, 2, 1, 2};
    vecs[1] = '{1, 0, 1, 1, 0, 0, 1};
    vecs[2] = '{2, 0, 1, 2, 0, 0, 1};
    vecs[3] = '{3, 0, 1, 3, 0, 0, 1};
    vecs[4] = '{4, 0, 0, 0, 2, 1, 2};
    vecs[5] = '{3, 1, 1, 3, 1, 0, 2};

    reset   = 1'b1;
    go      = 1'b0;
    done_in = 1'b0;
    lump_in = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_start", 32'(start_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rounds", 32'(rounds_done), 32'd0);
    check("rst_batch", 32'(batch_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 6; v++) begin
      lump_in      = 8'd0;
      done_in      = 1'b0;
      rounds_model = 0;
      @(negedge clk);
      bd_pulses = 0;
      starts    = 0;
      go        = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int r = 0; r < int'(NR); r++) begin
        int f;
        f = (r == vecs[v].fround) ? vecs[v].fault : ((vecs[v].fault == 4) ? 4 : 0);
        run_round(f);
        if (f == 1 || f == 2 || f == 3) break;
      end
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].e_err));
      check($sformatf("v%0d_code", v), 32'(err_code), 32'(vecs[v].e_code));
      check($sformatf("v%0d_rounds", v), 32'(rounds_done), 32'(vecs[v].e_rounds));
      check($sformatf("v%0d_batch", v), 32'(bd_pulses), 32'(vecs[v].e_batch));
      check($sformatf("v%0d_starts", v), 32'(starts), 32'(vecs[v].e_starts));
      check($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].e_err));
      if (vecs[v].e_err != 0) begin
        check($sformatf("v%0d_err_start", v), 32'(start_out), 32'd0);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check($sformatf("v%0d_recover_err", v), 32'(err), 32'd0);
        check($sformatf("v%0d_recover_busy", v), 32'(busy), 32'd0);
      end
    end

    // Reset asserted while waiting in GAP
    lump_in      = 8'd0;
    rounds_model = 0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    run_round(0);
    check("gap_busy", 32'(busy), 32'd1);
    check("gap_rounds", 32'(rounds_done), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("gaprst_start", 32'(start_out), 32'd0);
    check("gaprst_busy", 32'(busy), 32'd0);
    check("gaprst_rounds", 32'(rounds_done), 32'd0);
    check("gaprst_batch", 32'(batch_done), 32'd0);
    check("gaprst_err", 32'(err), 32'd0);
    check("gaprst_code", 32'(err_code), 32'd0);
    bd_pulses = 0;
    starts    = 0;
    repeat (3 * TD) @(negedge clk);
    check("gaprst_no_start", 32'(starts), 32'd0);
    check("gaprst_no_batch", 32'(bd_pulses), 32'd0);
    check("gaprst_idle", 32'(busy), 32'd0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
